// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package display_pkg;

  // Digit slot index; 0 is the rightmost digit.
  typedef logic [1:0] slot_t;

  localparam slot_t SLOT_MIN_ONES = 2'd0;
  localparam slot_t SLOT_MIN_TENS = 2'd1;
  localparam slot_t SLOT_HR_ONES  = 2'd2;
  localparam slot_t SLOT_HR_TENS  = 2'd3;

  localparam int unsigned MAX_HOUR   = 12;
  localparam int unsigned MAX_MINUTE = 59;

  // Out-of-range hours (0, 13..15) are shown as 12.
  function automatic logic [3:0] clamp_hour(input logic [3:0] h);
    if (h == 4'd0 || h > 4'(MAX_HOUR)) begin
      return 4'(MAX_HOUR);
    end
    return h;
  endfunction

  // Out-of-range minutes (60..63) are shown as 59.
  function automatic logic [5:0] clamp_minute(input logic [5:0] m);
    if (m > 6'(MAX_MINUTE)) begin
      return 6'(MAX_MINUTE);
    end
    return m;
  endfunction

endpackage

// File: rtl/bin_to_bcd_2dig.sv
// Combinational 0..99 binary to two-digit BCD converter using compare/subtract.
module bin_to_bcd_2dig (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // Pick the largest multiple of ten not exceeding the input; the last match wins.
  always_comb begin
    tens = 4'd0;
    ones = 4'(bin);
    for (int unsigned i = 1; i <= 9; i++) begin
      if (bin >= 7'(i * 10)) begin
        tens = 4'(i);
        ones = 4'(bin - 7'(i * 10));
      end
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Digit scan sequencer for the 7-segment driver: slot select, per-frame time
// snapshot in BCD, leading-zero blanking and set-mode field blinking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic       pm_In,
  input  logic       blink_Hours,
  input  logic       blink_Minutes,
  input  logic       enable,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic [1:0] digit_sel,
  output logic [1:0] anode_sel,
  output logic       display_On,
  output logic       am_Or_Pm,
  output logic       frame_Tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] presc_q;
  slot_t         slot_q;
  logic          slot_tick;
  logic          frame_end;

  logic [3:0]    d3_q, d2_q, d1_q, d0_q;
  logic          pm_q;
  logic          frame_q;
  // Set by the first snapshot; keeps the display dark after reset until then.
  logic          loaded_q;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_vis_q;
  logic          blinking;

  logic [3:0]    hr_tens, hr_ones, min_tens, min_ones;

  assign slot_tick = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_end = slot_tick && (slot_q == SLOT_HR_TENS);
  assign blinking  = blink_Hours | blink_Minutes;

  bin_to_bcd_2dig u_hour_bcd (
    .bin  ({3'b000, clamp_hour(hours)}),
    .tens (hr_tens),
    .ones (hr_ones)
  );

  bin_to_bcd_2dig u_min_bcd (
    .bin  ({1'b0, clamp_minute(minutes)}),
    .tens (min_tens),
    .ones (min_ones)
  );

  // Prescaler and slot counter; the slot wraps naturally from 3 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      slot_q  <= SLOT_MIN_ONES;
    end else if (slot_tick) begin
      presc_q <= '0;
      slot_q  <= slot_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Snapshot the time at frame boundaries only, so digits never tear mid-frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d3_q     <= 4'd0;
      d2_q     <= 4'd0;
      d1_q     <= 4'd0;
      d0_q     <= 4'd0;
      pm_q     <= 1'b0;
      frame_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      frame_q <= frame_end;
      if (frame_end) begin
        d3_q     <= hr_tens;
        d2_q     <= hr_ones;
        d1_q     <= min_tens;
        d0_q     <= min_ones;
        pm_q     <= pm_In;
        loaded_q <= 1'b1;
      end
    end
  end

  // Blink phase: held visible while no field blinks, so blinking starts lit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else if (!blinking) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else if (frame_end) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_vis_q <= ~blink_vis_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  // Per-slot enable: global enable, leading-zero blank and field blanking.
  always_comb begin
    display_On = enable & loaded_q;
    if (slot_q == SLOT_HR_TENS && d3_q == 4'd0) begin
      display_On = 1'b0;
    end
    if (!blink_vis_q && blink_Hours && slot_q[1]) begin
      display_On = 1'b0;
    end
    if (!blink_vis_q && blink_Minutes && !slot_q[1]) begin
      display_On = 1'b0;
    end
  end

  assign digit3     = d3_q;
  assign digit2     = d2_q;
  assign digit1     = d1_q;
  assign digit0     = d0_q;
  assign am_Or_Pm   = pm_q;
  assign frame_Tick = frame_q;
  assign digit_sel  = slot_q;
  assign anode_sel  = slot_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: the driver queues the expected frame content for each
// input vector; the monitor pops one entry per frame_Tick and checks digits,
// scan timing and per-slot display_On.
module tb_display_scan_ctrl;

  localparam int unsigned RDIV = 4;
  localparam int unsigned BFR  = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] hours = 4'd9;
  logic [5:0] minutes = 6'd5;
  logic       pm_In = 1'b1;
  logic       blink_Hours = 1'b0;
  logic       blink_Minutes = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic [1:0] digit_sel, anode_sel;
  logic       display_On, am_Or_Pm, frame_Tick;

  display_scan_ctrl #(
    .REFRESH_DIV  (RDIV),
    .BLINK_FRAMES (BFR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hours         (hours),
    .minutes       (minutes),
    .pm_In         (pm_In),
    .blink_Hours   (blink_Hours),
    .blink_Minutes (blink_Minutes),
    .enable        (enable),
    .digit3        (digit3),
    .digit2        (digit2),
    .digit1        (digit1),
    .digit0        (digit0),
    .digit_sel     (digit_sel),
    .anode_sel     (anode_sel),
    .display_On    (display_On),
    .am_Or_Pm      (am_Or_Pm),
    .frame_Tick    (frame_Tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       pm;
    logic [3:0] mask;  // expected display_On per slot, bit index = slot
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  bit         have_cur = 1'b0;
  bit         mon_en = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         last_slot_cyc = 0;
  int         last_tick_cyc = 0;
  bit         seen_slot = 1'b0;
  bit         seen_tick = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  logic [1:0] nxt_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: frame content on every frame_Tick, stability within a frame,
  // slot order/length and display_On at the first cycle of every slot.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (frame_Tick === 1'b1) begin
          if (seen_tick) check("frame_period", cyc - last_tick_cyc, 4 * RDIV);
          last_tick_cyc = cyc;
          seen_tick = 1'b1;
          check("tick_slot", digit_sel, 0);
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected: frame_Tick with empty scoreboard (t=%0t)", $time);
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            check("frame_digits", {digit3, digit2, digit1, digit0, am_Or_Pm},
                  {cur.d3, cur.d2, cur.d1, cur.d0, cur.pm});
          end
        end else if (have_cur) begin
          check("no_tear", {digit3, digit2, digit1, digit0, am_Or_Pm},
                {cur.d3, cur.d2, cur.d1, cur.d0, cur.pm});
        end
        if (digit_sel !== prev_sel) begin
          if (seen_slot) begin
            nxt_sel = prev_sel + 2'd1;
            check("slot_len", cyc - last_slot_cyc, RDIV);
            check("slot_order", digit_sel, nxt_sel);
          end
          last_slot_cyc = cyc;
          seen_slot = 1'b1;
          check("anode_eq_sel", anode_sel, digit_sel);
          if (have_cur) begin
            check($sformatf("display_on_slot%0d", digit_sel), display_On, cur.mask[digit_sel]);
          end
        end
      end
      prev_sel = digit_sel;
    end
  end

  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_Tick !== 1'b1 && n < 40);
    if (frame_Tick !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_tick: no frame_Tick within 40 cycles (t=%0t)", $time);
    end
  endtask

  // Apply a vector near the end of the current frame (or mid-frame when
  // early is set) and queue what the following frame must show.
  task automatic drive(input logic [3:0] h, input logic [5:0] m, input logic p,
                       input logic bh, input logic bm, input logic en, input bit early,
                       input logic [3:0] e3, input logic [3:0] e2, input logic [3:0] e1,
                       input logic [3:0] e0, input logic epm, input logic [3:0] emask);
    exp_t e;
    wait_tick();
    repeat (early ? 7 : 15) @(posedge clk);
    #2;
    hours = h;
    minutes = m;
    pm_In = p;
    blink_Hours = bh;
    blink_Minutes = bm;
    enable = en;
    e.d3 = e3;
    e.d2 = e2;
    e.d1 = e1;
    e.d0 = e0;
    e.pm = epm;
    e.mask = emask;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e0;
    repeat (3) @(negedge clk);
    check("rst_digit_sel", digit_sel, 0);
    check("rst_anode_sel", anode_sel, 0);
    check("rst_digits", {digit3, digit2, digit1, digit0}, 0);
    check("rst_am_pm", am_Or_Pm, 0);
    check("rst_display_on", display_On, 0);
    check("rst_frame_tick", frame_Tick, 0);

    // 9:05 PM, already on the inputs during reset.
    e0.d3 = 4'd0; e0.d2 = 4'd9; e0.d1 = 4'd0; e0.d0 = 4'd5; e0.pm = 1'b1; e0.mask = 4'b0111;
    sb.push_back(e0);
    reset_n = 1'b1;
    mon_en = 1'b1;

    //     h      m      pm    bh    bm    en   early  d3     d2     d1     d0    pm    mask
    drive(4'd12, 6'd59, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4'd1, 4'd2, 4'd5, 4'd9, 1'b0, 4'b1111);
    drive(4'd12, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 4'b1111);
    drive(4'd14, 6'd63, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4'd1, 4'd2, 4'd5, 4'd9, 1'b0, 4'b1111);
    drive(4'd0,  6'd0,  1'b1, 1'b0, 1'b0, 1'b1, 0, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 4'b1111);
    drive(4'd10, 6'd30, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b1111);
    drive(4'd10, 6'd30, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b0011);
    drive(4'd10, 6'd30, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b0011);
    drive(4'd10, 6'd30, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b1111);
    drive(4'd10, 6'd30, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b1111);
    drive(4'd10, 6'd30, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b0011);
    // Blink released while the hour field is hidden in slot 3: lit at once.
    drive(4'd10, 6'd30, 1'b0, 1'b0, 1'b0, 1'b1, 0, 4'd1, 4'd0, 4'd3, 4'd0, 1'b0, 4'b1111);
    #1;
    check("blink_release_slot", digit_sel, 3);
    check("blink_release_on", display_On, 1);
    drive(4'd5,  6'd7,  1'b0, 1'b1, 1'b1, 1'b1, 0, 4'd0, 4'd5, 4'd0, 4'd7, 1'b0, 4'b0111);
    drive(4'd5,  6'd7,  1'b0, 1'b1, 1'b1, 1'b1, 0, 4'd0, 4'd5, 4'd0, 4'd7, 1'b0, 4'b0000);
    drive(4'd11, 6'd45, 1'b1, 1'b0, 1'b0, 1'b0, 0, 4'd1, 4'd1, 4'd4, 4'd5, 1'b1, 4'b0000);
    drive(4'd11, 6'd45, 1'b1, 1'b0, 1'b0, 1'b1, 0, 4'd1, 4'd1, 4'd4, 4'd5, 1'b1, 4'b1111);

    // Last frame shows 11:45 PM; reset it mid-way through slot 2.
    wait_tick();
    repeat (9) @(posedge clk);
    #2;
    mon_en = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
    check("pre_reset_slot", digit_sel, 2);
    reset_n = 1'b0;
    #1;
    check("async_rst_digit_sel", digit_sel, 0);
    check("async_rst_anode_sel", anode_sel, 0);
    check("async_rst_digits", {digit3, digit2, digit1, digit0}, 0);
    check("async_rst_am_pm", am_Or_Pm, 0);
    check("async_rst_display_on", display_On, 0);
    check("async_rst_frame_tick", frame_Tick, 0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= RDIV; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("restart_slot_c%0d", i), digit_sel, (i == RDIV) ? 1 : 0);
      if (i == 2) check("restart_dark", display_On, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Feeds the 7-segment display driver. Generates the time-multiplexed digit/anode select sequence and the per-digit enable. Converts binary 12-hour time (hours, minutes, AM/PM) into four BCD digits, with leading-zero blanking and field blinking for time/alarm set mode. Sits between the clock/alarm time registers and the display driver; its outputs connect directly to the driver's digit, select, enable and AM/PM inputs.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (>=2); 100 MHz clk gives 1 kHz per digit, 250 Hz per frame.
BLINK_FRAMES, 125, frames per blink half-period (>=1); 0.5 s at the default refresh rate.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
hours  input  4  binary hour, valid 1..12
minutes  input  6  binary minute, valid 0..59
pm_In  input  1  1 = PM
blink_Hours  input  1  blink hour digits (set mode)
blink_Minutes  input  1  blink minute digits (set mode)
enable  input  1  0 = display fully blank
digit3  output  4  BCD hours tens
digit2  output  4  BCD hours ones
digit1  output  4  BCD minutes tens
digit0  output  4  BCD minutes ones
digit_sel  output  2  active digit slot, 0 = rightmost
anode_sel  output  2  anode select; always equal to digit_sel
display_On  output  1  enable for the current slot
am_Or_Pm  output  1  registered copy of the PM flag
frame_Tick  output  1  one-cycle pulse when slot 3 wraps to slot 0

Behaviour:
- Reset (asynchronous, active-low):
  - prescaler = 0, digit_sel = anode_sel = 0.
  - digit3..digit0 = 0, am_Or_Pm = 0, display_On = 0, frame_Tick = 0.
  - blink counter = 0, blink phase = visible (1).
- Prescaler:
  - Counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - slot_tick asserts for one cycle when the count equals REFRESH_DIV-1, then the count wraps to 0.
- Slot counter:
  - Advances 0->1->2->3->0 on each slot_tick.
  - digit_sel and anode_sel are the same register.
- Frame boundary (slot_tick while digit_sel == 3):
  - frame_Tick pulses the following cycle.
  - hours, minutes and pm_In are snapshotted, so digits change only at frame boundaries and never tear mid-frame.
  - Snapshot results appear on digit3..0 and am_Or_Pm one cycle after the boundary tick, together with digit_sel = 0.
- Snapshot conversion:
  - Hours: 10..12 -> digit3 = 1, digit2 = hours-10; 1..9 -> digit3 = 0, digit2 = hours.
  - Invalid hours (0, 13..15) are forced to 12.
  - Minutes: digit1 = minutes/10, digit0 = minutes%10. Minutes > 59 are forced to 59.
  - Implemented as compare/subtract; no divider.
- Blink:
  - The blink counter increments on each frame boundary.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles the blink phase.
  - When neither blink input is set, the counter is held at 0 and the phase at visible, so blinking always starts visible.
- display_On (combinational from registered state) is 1 only when all of these hold:
  - enable = 1;
  - not (digit_sel == 3 and digit3 == 0) (leading-zero blank);
  - not (blink phase hidden and blink_Hours and digit_sel in {2,3});
  - not (blink phase hidden and blink_Minutes and digit_sel in {0,1}).
- enable low does not stop scanning; counters keep running.
- Both blink inputs set: all four digits blink together.
- Reset mid-frame: everything returns to reset values immediately; the first snapshot is taken at the next frame boundary. The display stays dark until then (digits 0, leading-zero blank on slot 3).

Decomposition:
- Shared package display_pkg holds:
  - typedef slot_t (logic [1:0]);
  - slot constants SLOT_MIN_ONES = 0 .. SLOT_HR_TENS = 3;
  - constants MAX_HOUR = 12, MAX_MINUTE = 59.
- One natural sub-module, bin_to_bcd_2dig: a combinational 0..99 -> tens/ones converter, instantiated for hours and for minutes. All sequencing stays in the top module.

Test Plan:
1. REFRESH_DIV = 4, release reset -> digit_sel steps 0,1,2,3 every 4 clks; frame_Tick pulses once per 16 clks, in the cycle digit_sel returns to 0.
2. hours = 9, minutes = 5, pm_In = 1 held through a frame boundary -> digits 0,9,0,5; am_Or_Pm = 1; display_On = 0 in slot 3, 1 in slots 0..2.
3. hours = 12, minutes = 59 -> 1,2,5,9. Change minutes to 0 in mid-frame -> digits unchanged until the next frame_Tick, then 1,2,0,0. Also hours = 14, minutes = 63 -> 1,2,5,9.
4. BLINK_FRAMES = 2, blink_Hours = 1, hours = 10 -> slots 2,3 dark for 2 frames, lit for 2 frames, alternating; slots 0,1 always lit. Deassert blink -> slots 2,3 lit from the next cycle.
5. enable = 0 -> display_On = 0 in every slot while digit_sel keeps scanning.
6. Assert reset_n = 0 mid-slot with digit_sel = 2 -> all outputs zero in the same cycle. Release -> scan restarts at slot 0, with a full REFRESH_DIV count before slot 1.
